// File: rtl/tm1638_refresh_sequencer.sv
// tm1638_refresh_sequencer: keeps a TM1638 display refreshed through a 5-byte SPI controller
module tm1638_refresh_sequencer #(
  parameter int unsigned POWER_UP_CYCLES = 50_000_000,
  parameter int unsigned REFRESH_CYCLES = 10_000_000,
  parameter int unsigned BUSY_TIMEOUT = 1024,
  parameter logic [15:0] FRAMES_INIT = 16'h0000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] frame_in,
  input  logic [2:0]   brightness,
  input  logic         display_on,
  input  logic         update_req,
  input  logic         clear_err,
  input  logic         spi_busy,
  output logic         spi_activate,
  output logic         spi_cs,
  output logic [39:0]  spi_out_data,
  output logic [2:0]   spi_out_count,
  output logic         seq_busy,
  output logic [15:0]  frames_sent,
  output logic         timeout_err
);
  localparam int unsigned CMAX = POWER_UP_CYCLES > REFRESH_CYCLES ? POWER_UP_CYCLES : REFRESH_CYCLES;
  localparam int CW = CMAX > 1 ? $clog2(CMAX + 1) : 1;
  localparam int TW = BUSY_TIMEOUT > 1 ? $clog2(BUSY_TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {POWER_UP, IDLE, START, DATA, CTRL, SEND, AWAIT, DONE} state_t;
  state_t state, state_n, ret, ret_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [127:0] snap, snap_n;
  logic [2:0] bri, bri_n, q_count, q_count_n, count_n;
  logic [39:0] q_data, q_data_n, data_n;
  logic [15:0] frames_n;
  logic [1:0] k, k_n;
  logic on, on_n, pending, pending_n, busy_seen, busy_seen_n;
  logic act_n, cs_n, sbusy_n, err_n;
  // state and output registers; reset restarts the power-up delay
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= POWER_UP;
      ret <= IDLE;
      cnt <= CW'(POWER_UP_CYCLES);
      tmo <= '0;
      snap <= '0;
      bri <= '0;
      on <= 1'b0;
      k <= '0;
      q_data <= '0;
      q_count <= '0;
      pending <= 1'b0;
      busy_seen <= 1'b0;
      spi_activate <= 1'b0;
      spi_cs <= 1'b0;
      spi_out_data <= '0;
      spi_out_count <= '0;
      seq_busy <= 1'b0;
      frames_sent <= FRAMES_INIT;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      cnt <= cnt_n;
      tmo <= tmo_n;
      snap <= snap_n;
      bri <= bri_n;
      on <= on_n;
      k <= k_n;
      q_data <= q_data_n;
      q_count <= q_count_n;
      pending <= pending_n;
      busy_seen <= busy_seen_n;
      spi_activate <= act_n;
      spi_cs <= cs_n;
      spi_out_data <= data_n;
      spi_out_count <= count_n;
      seq_busy <= sbusy_n;
      frames_sent <= frames_n;
      timeout_err <= err_n;
    end
  end
  // sequence: 0x40, four address+data bursts, display control; each transfer goes SEND -> AWAIT -> ret
  always_comb begin
    state_n = state;
    ret_n = ret;
    cnt_n = cnt;
    tmo_n = tmo;
    snap_n = snap;
    bri_n = bri;
    on_n = on;
    k_n = k;
    q_data_n = q_data;
    q_count_n = q_count;
    pending_n = pending;
    busy_seen_n = busy_seen;
    act_n = spi_activate;
    cs_n = spi_cs;
    data_n = spi_out_data;
    count_n = spi_out_count;
    sbusy_n = seq_busy;
    frames_n = frames_sent;
    err_n = clear_err ? 1'b0 : timeout_err;
    case (state)
      POWER_UP: begin
        if (cnt == '0) state_n = START;
        else cnt_n = cnt - CW'(1);
      end
      IDLE: begin
        if (REFRESH_CYCLES != 0 && cnt != '0) cnt_n = cnt - CW'(1);
        if ((REFRESH_CYCLES != 0 && cnt == '0) || update_req || pending) state_n = START;
      end
      START: begin
        snap_n = frame_in;
        bri_n = brightness;
        on_n = display_on;
        pending_n = 1'b0;
        cnt_n = CW'(REFRESH_CYCLES);
        k_n = '0;
        sbusy_n = 1'b1;
        q_data_n = 40'h40;
        q_count_n = 3'd1;
        ret_n = DATA;
        state_n = SEND;
      end
      DATA: begin
        q_data_n = {snap[{k, 5'b0} +: 32], 4'hC, k, 2'b00};
        q_count_n = 3'd5;
        ret_n = k == 2'd3 ? CTRL : DATA;
        k_n = k + 2'd1;
        state_n = SEND;
      end
      CTRL: begin
        q_data_n = {32'h0, on ? {5'b10001, bri} : 8'h80};
        q_count_n = 3'd1;
        ret_n = DONE;
        state_n = SEND;
      end
      SEND: begin
        if (!spi_busy) begin
          data_n = q_data;
          count_n = q_count;
          cs_n = 1'b1;
          act_n = 1'b1;
          busy_seen_n = 1'b0;
          tmo_n = '0;
          state_n = AWAIT;
        end
      end
      AWAIT: begin
        if (!busy_seen) begin
          if (spi_busy) begin
            busy_seen_n = 1'b1;
            act_n = 1'b0;
          end else if (tmo == TW'(BUSY_TIMEOUT - 1)) begin
            err_n = !clear_err;
            act_n = 1'b0;
            cs_n = 1'b0;
            sbusy_n = 1'b0;
            state_n = IDLE;
          end else tmo_n = tmo + TW'(1);
        end else if (!spi_busy) state_n = ret;
      end
      DONE: begin
        frames_n = frames_sent + 16'd1;
        sbusy_n = 1'b0;
        cs_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state != POWER_UP && state != IDLE && update_req) pending_n = 1'b1;
  end
endmodule

// File: tb/tb_tm1638_refresh_sequencer.sv
// tb_tm1638_refresh_sequencer: scoreboard bench with a behavioural SPI busy model
module tb_tm1638_refresh_sequencer;
  typedef struct packed { logic [2:0] cnt; logic [39:0] data; } xfer_t;
  logic clk = 1'b0;
  logic reset_n, rst_b_n, update_req, clear_err, display_on;
  logic spi_busy = 1'b0, b_busy = 1'b0, no_busy = 1'b0;
  logic [127:0] frame_in;
  logic [2:0] brightness;
  logic spi_activate, spi_cs, seq_busy, timeout_err;
  logic [39:0] spi_out_data;
  logic [2:0] spi_out_count;
  logic [15:0] frames_sent;
  logic b_act, b_cs, b_seq, b_err;
  logic [39:0] b_data;
  logic [2:0] b_count;
  logic [15:0] b_frames;
  xfer_t exp_q[$];
  xfer_t e;
  int checks = 0, errors = 0, xfers = 0, viol = 0, blen = 0, blen_b = 0;
  logic act_q = 1'b0, both_q = 1'b0;
  logic [39:0] last_data = '0;

  tm1638_refresh_sequencer #(.POWER_UP_CYCLES(20), .REFRESH_CYCLES(0)) dut (
    .clk(clk), .reset_n(reset_n), .frame_in(frame_in), .brightness(brightness),
    .display_on(display_on), .update_req(update_req), .clear_err(clear_err), .spi_busy(spi_busy),
    .spi_activate(spi_activate), .spi_cs(spi_cs), .spi_out_data(spi_out_data),
    .spi_out_count(spi_out_count), .seq_busy(seq_busy), .frames_sent(frames_sent),
    .timeout_err(timeout_err));

  tm1638_refresh_sequencer #(.POWER_UP_CYCLES(20), .REFRESH_CYCLES(100), .FRAMES_INIT(16'hFFFE)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .frame_in(frame_in), .brightness(brightness),
    .display_on(display_on), .update_req(1'b0), .clear_err(1'b0), .spi_busy(b_busy),
    .spi_activate(b_act), .spi_cs(b_cs), .spi_out_data(b_data),
    .spi_out_count(b_count), .seq_busy(b_seq), .frames_sent(b_frames),
    .timeout_err(b_err));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_refresh(input logic [127:0] f, input logic [2:0] b, input logic on);
    logic [39:0] d;
    exp_q.push_back('{cnt: 3'd1, data: 40'h40});
    for (int k = 0; k < 4; k++) begin
      d = 40'(192 + 4 * k);
      for (int j = 0; j < 4; j++) d[8 * (j + 1) +: 8] = f[8 * (4 * k + j) +: 8];
      exp_q.push_back('{cnt: 3'd5, data: d});
    end
    exp_q.push_back('{cnt: 3'd1, data: 40'(on ? (8'h88 | {5'b0, b}) : 8'h80)});
  endtask

  task automatic randomize_inputs();
    frame_in = {$urandom, $urandom, $urandom, $urandom};
    brightness = 3'($urandom);
    display_on = 1'($urandom);
  endtask

  task automatic trigger();
    @(negedge clk);
    update_req = 1'b1;
    push_refresh(frame_in, brightness, display_on);
    @(negedge clk);
    update_req = 1'b0;
    repeat (3) @(negedge clk);
    randomize_inputs();
  endtask

  task automatic wait_frames(input logic [15:0] target, input string name);
    int n;
    n = 0;
    while (frames_sent !== target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(frames_sent), 64'(target));
  endtask

  task automatic check_quiet(input string name);
    int n;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (spi_activate) n++;
    end
    chk(name, 64'(n), 64'd0);
  endtask

  // busy model for the main instance: rises after an activate, stays high 1..5 cycles
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      spi_busy <= 1'b0;
      blen <= 0;
    end else if (spi_busy) begin
      if (blen == 0) spi_busy <= 1'b0;
      else blen <= blen - 1;
    end else if (spi_activate && !no_busy) begin
      spi_busy <= 1'b1;
      blen <= int'($urandom_range(0, 4));
    end

  // busy model for the periodic-refresh instance
  always @(posedge clk or negedge rst_b_n)
    if (!rst_b_n) begin
      b_busy <= 1'b0;
      blen_b <= 0;
    end else if (b_busy) begin
      if (blen_b == 0) b_busy <= 1'b0;
      else blen_b <= blen_b - 1;
    end else if (b_act) begin
      b_busy <= 1'b1;
      blen_b <= int'($urandom_range(0, 4));
    end

  // monitor: every rising spi_activate is a transfer, compared against the scoreboard head
  always @(negedge clk) begin
    if (reset_n && spi_activate && !act_q) begin
      xfers = xfers + 1;
      last_data = spi_out_data;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got count %0d data %h, none expected", spi_out_count, spi_out_data);
      end else begin
        e = exp_q.pop_front();
        chk("xfer", {20'h0, spi_cs, spi_out_count, spi_out_data}, {20'h0, 1'b1, e.cnt, e.data});
      end
    end
    if (reset_n && spi_activate && spi_busy && both_q) viol = viol + 1;
    both_q = spi_activate && spi_busy;
    act_q = spi_activate;
  end

  initial begin
    int n, x0;
    reset_n = 1'b0;
    rst_b_n = 1'b0;
    update_req = 1'b0;
    clear_err = 1'b0;
    brightness = 3'd7;
    display_on = 1'b1;
    for (int i = 0; i < 16; i++) frame_in[8 * i +: 8] = 8'(i);
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({spi_activate, spi_cs, spi_out_data, spi_out_count, seq_busy, frames_sent, timeout_err}), 64'd0);
    push_refresh(frame_in, brightness, display_on);
    reset_n = 1'b1;
    check_quiet("powerup_quiet");
    wait_frames(16'd1, "first_frame");
    chk("seq_busy_idle", 64'(seq_busy), 64'd0);
    chk("first_drained", 64'(exp_q.size()), 64'd0);
    for (int r = 0; r < 4; r++) begin
      randomize_inputs();
      trigger();
      wait_frames(16'(2 + r), "random_frame");
    end
    display_on = 1'b0;
    brightness = 3'd5;
    trigger();
    wait_frames(16'd6, "off_frame");
    chk("ctrl_off", 64'(last_data[7:0]), 64'h80);
    display_on = 1'b1;
    brightness = 3'd5;
    trigger();
    wait_frames(16'd7, "on_frame");
    chk("ctrl_on", 64'(last_data[7:0]), 64'h8D);
    trigger();
    repeat (2) @(negedge clk);
    update_req = 1'b1;
    push_refresh(frame_in, brightness, display_on);
    @(negedge clk);
    update_req = 1'b0;
    repeat (10) @(negedge clk);
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    wait_frames(16'd9, "pending_frames");
    repeat (200) @(negedge clk);
    chk("no_third_refresh", 64'(frames_sent), 64'd9);
    no_busy = 1'b1;
    @(negedge clk);
    update_req = 1'b1;
    exp_q.push_back('{cnt: 3'd1, data: 40'h40});
    @(negedge clk);
    update_req = 1'b0;
    n = 0;
    while (!spi_activate && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_activate", 64'(spi_activate), 64'd1);
    n = 0;
    while (!timeout_err && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 64'(n), 64'd1024);
    chk("tmo_err", 64'(timeout_err), 64'd1);
    chk("tmo_seq_busy", 64'(seq_busy), 64'd0);
    chk("tmo_activate_low", 64'(spi_activate), 64'd0);
    chk("tmo_frames", 64'(frames_sent), 64'd9);
    repeat (5) @(negedge clk);
    chk("tmo_sticky", 64'(timeout_err), 64'd1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("clear_err", 64'(timeout_err), 64'd0);
    chk("tmo_drained", 64'(exp_q.size()), 64'd0);
    no_busy = 1'b0;
    trigger();
    wait_frames(16'd10, "recover_frame");
    x0 = xfers;
    trigger();
    n = 0;
    while (xfers < x0 + 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_burst2", 64'(xfers), 64'(x0 + 4));
    reset_n = 1'b0;
    #1;
    chk("midburst_reset", 64'({spi_activate, spi_cs, spi_out_data, spi_out_count, seq_busy, frames_sent, timeout_err}), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_refresh(frame_in, brightness, display_on);
    reset_n = 1'b1;
    check_quiet("restart_quiet");
    wait_frames(16'd1, "restart_frame");
    chk("restart_drained", 64'(exp_q.size()), 64'd0);
    chk("b_reset", 64'(b_frames), 64'hFFFE);
    @(negedge clk);
    rst_b_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      logic [15:0] start;
      start = b_frames;
      n = 0;
      while (b_frames == start && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("b_frames", 64'(b_frames), 64'(16'(16'hFFFF + r)));
      if (r > 0) chk("b_period", 64'(n >= 100 && n < 400), 64'd1);
    end
    chk("act_after_busy", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
